img_conv_pipe: RTL and testbench

IMG_CONV_PIPE -- requirements
Module: img_conv_pipe

---
 rtl/img_conv_pipe_pkg.sv | 8 +
 rtl/img_conv_pipe_sat_round.sv | 12 +
 rtl/img_conv_pipe.sv | 114 +++++++++++
 tb/tb_img_conv_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_conv_pipe_pkg.sv
// img_pkg: shared FSM states, sum-width helper and default Laplacian kernel.
package img_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
  localparam logic [53:0] LAPLACE_3X3 = {{4{6'h3f}}, 6'h08, {4{6'h3f}}};
  function automatic int sum_width(input int pxl_bits, input int coef_bits, input int taps);
    return pxl_bits + coef_bits + $clog2(taps);
  endfunction
endpackage

// File: rtl/img_conv_pipe_sat_round.sv
// sat_round: clamps a signed value into a narrower signed range.
module sat_round #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  assign out_o = in_i > MAX_V ? MAX_V[OUT_W-1:0] : in_i < MIN_V ? MIN_V[OUT_W-1:0] : in_i[OUT_W-1:0];
endmodule

// File: rtl/img_conv_pipe.sv
// img_conv_pipe: raster-scan 2D convolution with a 2-stage multiply/sum pipeline.
module img_conv_pipe
  import img_pkg::*;
#(
  parameter int IMG_WD     = 64,
  parameter int IMG_HT     = 64,
  parameter int COORD_BITS = 8,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12,
  parameter int COEF_BITS  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  border_zero,
  input  logic [WIN_HT*WIN_WD*COEF_BITS-1:0]    coef_flat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [COORD_BITS-1:0]                 rd_x,
  output logic [COORD_BITS-1:0]                 rd_y,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]     rd_data_flat,
  output logic                                  wr_en,
  output logic [COORD_BITS-1:0]                 wr_x,
  output logic [COORD_BITS-1:0]                 wr_y,
  output logic signed [PXL_BITS-1:0]            wr_data_pxl,
  input  logic                                  wr_ready
);
  localparam int TAPS = WIN_HT * WIN_WD;
  localparam int PW   = PXL_BITS + COEF_BITS;
  localparam int SW   = sum_width(PXL_BITS, COEF_BITS, TAPS);
  localparam int HX   = WIN_WD / 2;
  localparam int HY   = WIN_HT / 2;
  state_e state_q, state_d;
  logic [COORD_BITS-1:0] cur_x_q, cur_y_q, x1_q, y1_q, x2_q, y2_q;
  logic v1_q, v2_q, bord1_q, bz_q;
  logic [TAPS*COEF_BITS-1:0] coef_q;
  logic signed [PW-1:0] prod_q [TAPS];
  logic signed [PW-1:0] prod_d [TAPS];
  logic signed [SW-1:0] sum_q, sum_d;
  logic stall, last_col, last_row, edge_px;
  assign stall    = v2_q & ~wr_ready;
  assign rd_en    = state_q == SCAN && !stall;
  assign rd_x     = cur_x_q;
  assign rd_y     = cur_y_q;
  assign busy     = state_q == SCAN || state_q == DRAIN;
  assign done     = state_q == DONE;
  assign wr_en    = v2_q;
  assign wr_x     = x2_q;
  assign wr_y     = y2_q;
  assign last_col = cur_x_q == COORD_BITS'(IMG_WD - 1);
  assign last_row = cur_y_q == COORD_BITS'(IMG_HT - 1);
  assign edge_px  = cur_x_q < COORD_BITS'(HX) || cur_x_q > COORD_BITS'(IMG_WD - 1 - HX) ||
                    cur_y_q < COORD_BITS'(HY) || cur_y_q > COORD_BITS'(IMG_HT - 1 - HY);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SCAN : IDLE;
      SCAN:    state_d = rd_en && last_col && last_row ? DRAIN : SCAN;
      // leave once the final pixel is handed off this cycle, so done follows the last write
      DRAIN:   state_d = !v1_q && !stall ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PW'($signed(rd_data_flat[k*PXL_BITS +: PXL_BITS])) *
                  PW'($signed(coef_q[k*COEF_BITS +: COEF_BITS]));
      sum_d = sum_d + SW'(prod_q[k]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      bord1_q <= 1'b0;
      bz_q    <= 1'b0;
      coef_q  <= '0;
      sum_q   <= '0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        coef_q <= coef_flat;
        bz_q   <= border_zero;
      end
      if (rd_en) begin
        cur_x_q <= last_col ? '0 : cur_x_q + COORD_BITS'(1);
        cur_y_q <= last_col ? (last_row ? '0 : cur_y_q + COORD_BITS'(1)) : cur_y_q;
      end
      if (!stall) begin
        v1_q    <= rd_en;
        x1_q    <= cur_x_q;
        y1_q    <= cur_y_q;
        bord1_q <= bz_q & edge_px;
        for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
        v2_q    <= v1_q;
        x2_q    <= x1_q;
        y2_q    <= y1_q;
        sum_q   <= bord1_q ? '0 : sum_d;
      end
    end
  end
  sat_round #(.IN_W(SW), .OUT_W(PXL_BITS)) u_sat (.in_i(sum_q), .out_o(wr_data_pxl));
endmodule

// File: tb/tb_img_conv_pipe.sv
// tb_img_conv_pipe: scoreboard bench for 4x4 and 5x5 instances of img_conv_pipe.
module tb_img_conv_pipe;
  typedef logic [24:0][11:0] img_t;
  typedef struct {int x; int y; int d;} pix_t;
  typedef struct {int s; int ctr; int nbr; logic bz; logic stl; int exp;} vec_t;
  logic clk, rst, start4, start5, border_zero, wr_ready, act;
  logic [53:0] coef_flat;
  logic busy4, done4, rd_en4, wr_en4, busy5, done5, rd_en5, wr_en5;
  logic [7:0] rd_x4, rd_y4, wr_x4, wr_y4, rd_x5, rd_y5, wr_x5, wr_y5;
  logic signed [11:0] wr_data4, wr_data5;
  logic [107:0] rd_data4, rd_data5;
  logic m_busy, m_done, m_rd_en, m_wr_en;
  logic [7:0] m_rd_x, m_rd_y, m_wr_x, m_wr_y;
  logic signed [11:0] m_wr_data;
  img_t img;
  pix_t exp_q[$];
  int rdq[$];
  int tests, fails, cyc, nwr, ndone, lastw, t;
  logic chk_lat;
  pix_t e;
  logic signed [11:0] got [5][5];
  logic signed [11:0] ref_got [5][5];
  logic [53:0] lap, box;
  vec_t vt [7];

  img_conv_pipe #(.IMG_WD(4), .IMG_HT(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .border_zero(border_zero), .coef_flat(coef_flat),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_x(rd_x4), .rd_y(rd_y4),
    .rd_data_flat(rd_data4), .wr_en(wr_en4), .wr_x(wr_x4), .wr_y(wr_y4),
    .wr_data_pxl(wr_data4), .wr_ready(wr_ready));
  img_conv_pipe #(.IMG_WD(5), .IMG_HT(5)) u5 (
    .clk(clk), .rst(rst), .start(start5), .border_zero(border_zero), .coef_flat(coef_flat),
    .busy(busy5), .done(done5), .rd_en(rd_en5), .rd_x(rd_x5), .rd_y(rd_y5),
    .rd_data_flat(rd_data5), .wr_en(wr_en5), .wr_x(wr_x5), .wr_y(wr_y5),
    .wr_data_pxl(wr_data5), .wr_ready(wr_ready));

  assign m_busy    = act ? busy5 : busy4;
  assign m_done    = act ? done5 : done4;
  assign m_rd_en   = act ? rd_en5 : rd_en4;
  assign m_rd_x    = act ? rd_x5 : rd_x4;
  assign m_rd_y    = act ? rd_y5 : rd_y4;
  assign m_wr_en   = act ? wr_en5 : wr_en4;
  assign m_wr_x    = act ? wr_x5 : wr_x4;
  assign m_wr_y    = act ? wr_y5 : wr_y4;
  assign m_wr_data = act ? wr_data5 : wr_data4;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampi(input int v, input int n);
    return v < 0 ? 0 : v > n - 1 ? n - 1 : v;
  endfunction
  // frame buffer replicates edge pixels for out-of-image window taps
  function automatic logic [107:0] win(input int x, input int y, input int w, input int h, input img_t im);
    logic [107:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*12 +: 12] = im[clampi(y+r-1, h)*5 + clampi(x+c-1, w)];
    return v;
  endfunction
  function automatic int model(input int x, input int y, input int w, input int h, input logic bz,
                               input logic [53:0] cf, input img_t im);
    int s = 0;
    if (bz && (x < 1 || y < 1 || x > w-2 || y > h-2)) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'($signed(im[clampi(y+r-1, h)*5 + clampi(x+c-1, w)])) * int'($signed(cf[(r*3+c)*6 +: 6]));
    return s > 2047 ? 2047 : s < -2048 ? -2048 : s;
  endfunction
  function automatic logic [53:0] mk_coef(input int ctr, input int ring);
    logic [53:0] cf;
    for (int k = 0; k < 9; k++) cf[k*6 +: 6] = 6'(k == 4 ? ctr : ring);
    return cf;
  endfunction

  always_comb rd_data4 = win(int'(rd_x4), int'(rd_y4), 4, 4, img);
  always_comb rd_data5 = win(int'(rd_x5), int'(rd_y5), 5, 5, img);

  task automatic check(input string nm, input longint a, input longint x);
    tests++;
    if (a != x) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, x);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (m_rd_en) rdq.push_back(cyc);
    if (m_wr_en && wr_ready) begin
      nwr++;
      lastw = cyc;
      if (m_wr_x < 5 && m_wr_y < 5) got[m_wr_y][m_wr_x] = m_wr_data;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: write at (%0d,%0d) with empty scoreboard", m_wr_x, m_wr_y);
      end else begin
        e = exp_q.pop_front();
        check("wr_x", m_wr_x, e.x);
        check("wr_y", m_wr_y, e.y);
        check("wr_data", m_wr_data, e.d);
      end
      if (rdq.size() != 0) begin
        t = rdq.pop_front();
        if (chk_lat) check("rd_to_wr_latency", cyc - t, 2);
      end
    end
    if (m_done) begin
      ndone++;
      check("done_after_last_wr", cyc - lastw, 1);
    end
  end

  task automatic begin_frame(input logic s, input logic bz, input logic [53:0] cf, input logic lat);
    int w = s ? 5 : 4;
    act = s;
    border_zero = bz;
    coef_flat = cf;
    nwr = 0;
    ndone = 0;
    chk_lat = lat;
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) got[y][x] = 12'sh5a5;
    for (int y = 0; y < w; y++)
      for (int x = 0; x < w; x++) exp_q.push_back('{x, y, model(x, y, w, w, bz, cf, img)});
    if (s) start5 = 1'b1; else start4 = 1'b1;
    @(posedge clk) #1;
    start4 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic finish_frame(input logic stl);
    int w = act ? 5 : 4;
    for (int k = 0; k < 600 && !m_done; k++) begin
      @(posedge clk) #1;
      if (stl) wr_ready = $urandom_range(0, 2) != 0;
    end
    wr_ready = 1'b1;
    if (!m_done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done not seen within 600 cycles");
    end
    @(posedge clk) #1;
    check("queue_drained", exp_q.size(), 0);
    check("write_count", nwr, w * w);
    check("done_pulses", ndone, 1);
    check("busy_after_done", m_busy, 0);
    exp_q.delete();
    rdq.delete();
  endtask

  task automatic run_frame(input logic s, input logic bz, input logic [53:0] cf, input logic stl);
    begin_frame(s, bz, cf, !stl);
    finish_frame(stl);
  endtask

  task automatic wait_for(input logic wr, input int x, input int y);
    logic hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk) #1;
      hit = wr ? (m_wr_en && m_wr_x == 8'(x) && m_wr_y == 8'(y)) : (m_rd_en && m_rd_x == 8'(x) && m_rd_y == 8'(y));
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout: %s at (%0d,%0d) never seen", wr ? "write" : "read", x, y);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [28:0] snap;
    logic [7:0] srx;
    tests = 0; fails = 0; cyc = 0; nwr = 0; ndone = 0; lastw = 0; chk_lat = 1'b0;
    rst = 1'b1; start4 = 1'b0; start5 = 1'b0; wr_ready = 1'b1; border_zero = 1'b0;
    coef_flat = '0; act = 1'b0; img = '0;
    lap = mk_coef(8, -1);
    box = mk_coef(1, 1);
    vt[0] = '{0,   100,   100, 1'b0, 1'b0,     0};
    vt[1] = '{0,  2047, -2048, 1'b0, 1'b0,  2047};
    vt[2] = '{0, -2048,  2047, 1'b0, 1'b0, -2048};
    vt[3] = '{0,    10,     0, 1'b0, 1'b0,    80};
    vt[4] = '{0,    10,     0, 1'b0, 1'b1,    80};
    vt[5] = '{0,    10,     0, 1'b1, 1'b0,    80};
    vt[6] = '{1,    50,    -3, 1'b0, 1'b1,   424};
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs_u4", {busy4, done4, rd_en4, wr_en4, rd_x4, rd_y4, wr_x4, wr_y4, wr_data4}, 0);
    check("rst_outs_u5", {busy5, done5, rd_en5, wr_en5, rd_x5, rd_y5, wr_x5, wr_y5, wr_data5}, 0);
    rst = 1'b0;
    @(posedge clk) #1;
    check("post_rst_u4", {busy4, done4, rd_en4, wr_en4, rd_x4, rd_y4, wr_x4, wr_y4, wr_data4}, 0);
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 25; k++) img[k] = 12'(vt[i].nbr);
      img[6] = 12'(vt[i].ctr);
      run_frame(vt[i].s, vt[i].bz, lap, vt[i].stl);
      check("centre_pixel", got[1][1], vt[i].exp);
    end
    // zeroed border on a random 5x5 frame
    for (int k = 0; k < 25; k++) img[k] = 12'($urandom);
    run_frame(1'b1, 1'b1, lap, 1'b0);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        if (x == 0 || y == 0 || x == 4 || y == 4) check("border_zero", got[y][x], 0);
    // stall for three cycles mid-row, compared against an unstalled run
    for (int k = 0; k < 25; k++) img[k] = 12'($urandom);
    run_frame(1'b0, 1'b0, lap, 1'b0);
    ref_got = got;
    begin_frame(1'b0, 1'b0, lap, 1'b0);
    wait_for(1'b1, 1, 1);
    wr_ready = 1'b0;
    snap = {m_wr_en, m_wr_x, m_wr_y, m_wr_data};
    srx = m_rd_x;
    repeat (3) begin
      @(posedge clk) #1;
      check("stall_wr_hold", {m_wr_en, m_wr_x, m_wr_y, m_wr_data}, snap);
      check("stall_rd_x", m_rd_x, srx);
      check("stall_rd_en", m_rd_en, 0);
    end
    wr_ready = 1'b1;
    finish_frame(1'b0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) check("stall_vs_ref", got[y][x], ref_got[y][x]);
    // reset in the middle of a scan, then a clean frame
    begin_frame(1'b0, 1'b0, lap, 1'b1);
    wait_for(1'b0, 2, 1);
    rst = 1'b1;
    @(posedge clk) #1;
    check("rst_mid_outs", {busy4, done4, rd_en4, wr_en4, rd_x4, rd_y4, wr_x4, wr_y4, wr_data4}, 0);
    rst = 1'b0;
    exp_q.delete();
    rdq.delete();
    run_frame(1'b0, 1'b0, lap, 1'b0);
    // second start and new coefficients while busy must not disturb the frame
    begin_frame(1'b0, 1'b0, lap, 1'b1);
    repeat (4) @(posedge clk) #1;
    start4 = 1'b1;
    coef_flat = box;
    border_zero = 1'b1;
    @(posedge clk) #1;
    start4 = 1'b0;
    finish_frame(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
